// File: rtl/fifo_rd_fwft_if.sv
// fifo_rd_fwft_if: FIFO read port plus FWFT valid/ready stream of the read-side output stage.
interface fifo_rd_fwft_if #(parameter int DSIZE = 8);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             flush;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic             out_ready;
  logic [1:0]       buf_cnt;
  modport master (output rempty, rdata, flush, out_ready, input rinc, out_valid, out_data, buf_cnt);
  modport slave (input rempty, rdata, flush, out_ready, output rinc, out_valid, out_data, buf_cnt);
endinterface

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: two-word first-word-fall-through output stage; the skid register keeps rinc independent of out_ready when not full.
module fifo_rd_fwft #(parameter int DSIZE = 8) (
  input logic           rclk,
  input logic           rrst_n,
  fifo_rd_fwft_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t           r_state, w_state;
  logic [DSIZE-1:0] r_head, r_skid, w_head, w_skid;
  logic             w_pop, w_push;
  assign w_pop         = (r_state != EMPTY) & bus.out_ready;
  assign w_push        = ~bus.rempty & ~bus.flush & ((r_state != TWO) | w_pop);
  assign bus.rinc      = w_push;
  assign bus.out_valid = r_state != EMPTY;
  assign bus.out_data  = r_head;
  assign bus.buf_cnt   = r_state;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state;
      r_head  <= w_head;
      r_skid  <= w_skid;
    end
  // flush only drops the count; data registers keep stale contents
  always_comb begin
    w_state = r_state;
    w_head  = r_head;
    w_skid  = r_skid;
    if (bus.flush) w_state = EMPTY;
    else
      case (r_state)
        EMPTY: if (w_push) begin
          w_head  = bus.rdata;
          w_state = ONE;
        end
        ONE: begin
          w_head  = (w_push & w_pop) ? bus.rdata : r_head;
          w_skid  = (w_push & ~w_pop) ? bus.rdata : r_skid;
          w_state = (w_push & ~w_pop) ? TWO : (~w_push & w_pop) ? EMPTY : ONE;
        end
        TWO: if (w_pop) begin
          w_head  = r_skid;
          w_skid  = w_push ? bus.rdata : r_skid;
          w_state = w_push ? TWO : ONE;
        end
        default: w_state = EMPTY;
      endcase
  end
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: vector table, directed corner cases and random traffic against a queue-based model.
module tb_fifo_rd_fwft;
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;
  fifo_rd_fwft_if #(.DSIZE(8)) bus();
  fifo_rd_fwft #(.DSIZE(8)) dut (.rclk(rclk), .rrst_n(rrst_n), .bus(bus.slave));
  logic [7:0] src[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       add;
    logic [7:0] val;
    logic       rdy;
    logic       fl;
    logic       rinc;
    logic       valid;
    logic [7:0] data;
    logic [1:0] cnt;
  } vec_t;
  vec_t tv[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input logic rdy, input logic fl, output logic a_rinc, output logic a_valid,
                       output logic [7:0] a_data, output logic [1:0] a_cnt);
    logic e_rinc, pop;
    bus.out_ready = rdy;
    bus.flush     = fl;
    bus.rempty    = src.size() == 0;
    bus.rdata     = src.size() != 0 ? src[0] : 8'hEE;
    #1;
    a_rinc  = bus.rinc;
    a_valid = bus.out_valid;
    a_data  = bus.out_data;
    a_cnt   = bus.buf_cnt;
    pop     = mq.size() != 0 && rdy;
    e_rinc  = src.size() != 0 && !fl && (mq.size() < 2 || pop);
    chk("rinc", a_rinc, e_rinc);
    chk("out_valid", a_valid, mq.size() != 0);
    chk("buf_cnt", a_cnt, mq.size());
    if (mq.size() != 0) chk("out_data", a_data, mq[0]);
    if (pop) popped.push_back(mq[0]);
    @(posedge rclk);
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (e_rinc) mq.push_back(src[0]);
    end
    if (e_rinc) void'(src.pop_front());
    @(negedge rclk);
  endtask
  initial begin
    logic       r, v;
    logic [7:0] d;
    logic [1:0] c;
    logic       rdy;
    tv[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    tv[4]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 2'd1};
    tv[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 2'd2};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 2'd2};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 2'd1};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    tv[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[12] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1};
    tv[13] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 2'd2};
    tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 2'd1};
    bus.rempty = 1'b1;
    bus.rdata = 8'h00;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge rclk);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset buf_cnt", bus.buf_cnt, 2'd0);
    chk("reset out_data", bus.out_data, 8'h00);
    chk("reset rinc", bus.rinc, 1'b0);
    rrst_n = 1'b1;
    @(negedge rclk);
    for (int i = 0; i < 16; i++) begin
      if (tv[i].add) src.push_back(tv[i].val);
      apply(tv[i].rdy, tv[i].fl, r, v, d, c);
      chk($sformatf("vec%0d rinc", i), r, tv[i].rinc);
      chk($sformatf("vec%0d out_valid", i), v, tv[i].valid);
      chk($sformatf("vec%0d buf_cnt", i), c, tv[i].cnt);
      if (tv[i].valid) chk($sformatf("vec%0d out_data", i), d, tv[i].data);
    end
    popped.delete();
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    for (int i = 0; i < 18; i++) begin
      apply(1'b1, 1'b0, r, v, d, c);
      if (i < 16) chk("stream rinc", r, 1'b1);
      if (i > 0 && i < 17) chk("stream out_valid", v, 1'b1);
    end
    chk("stream pop count", popped.size(), 16);
    for (int i = 0; i < popped.size() && i < 16; i++) chk("stream order", popped[i], i);
    popped.delete();
    for (int i = 0; i < 6; i++) src.push_back(8'h30 + 8'(i));
    for (int k = 0; k < 3; k++)
      foreach (tv[j]) if (j < 6) apply(j == 0 || j == 3 || j == 4, 1'b0, r, v, d, c);
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, r, v, d, c);
    chk("toggle pop count", popped.size(), 6);
    for (int i = 0; i < popped.size() && i < 6; i++) chk("toggle order", popped[i], 8'h30 + i);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && src.size() < 8) src.push_back(8'($urandom));
      rdy = $urandom_range(0, 3) != 0;
      apply(rdy, $urandom_range(0, 19) == 0, r, v, d, c);
      chk("buf_cnt bound", c <= 2'd2, 1'b1);
    end
    src.delete();
    for (int i = 0; i < 4 && mq.size() != 0; i++) apply(1'b1, 1'b0, r, v, d, c);
    src.push_back(8'hC1);
    src.push_back(8'hC2);
    repeat (3) apply(1'b0, 1'b0, r, v, d, c);
    chk("pre-reset buf_cnt", c, 2'd2);
    #2 rrst_n = 1'b0;
    src.delete();
    bus.rempty = 1'b1;
    #1;
    chk("async reset out_valid", bus.out_valid, 1'b0);
    chk("async reset buf_cnt", bus.buf_cnt, 2'd0);
    chk("async reset rinc", bus.rinc, 1'b0);
    mq.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (2) apply(1'b1, 1'b0, r, v, d, c);
    src.push_back(8'hD7);
    repeat (3) apply(1'b1, 1'b0, r, v, d, c);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
